// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared 16-bit memory bus.
// Each granted access runs IDLE -> ACCESS -> RESP, one cycle per state.

package mem_bus_pkg;
    // Active-low strobe encodings shared with the memory256x16 chips.
    typedef enum logic {MEM_WR = 1'b0, MEM_WR_OFF = 1'b1} wr_cond_code_t;
    typedef enum logic {MEM_RD = 1'b0, MEM_RD_OFF = 1'b1} rd_cond_code_t;
endpackage

module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset_L,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] mem_address,
    inout  wire  [DATA_W-1:0] mem_data,
    output wr_cond_code_t     mem_we_L,
    output rd_cond_code_t     mem_re_L,
    output logic              mem_active
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state_reg, state_next;
    logic                last_reg, last_next;
    logic                win_reg, win_next;
    logic                we_reg, we_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic                pick;

    logic [1:0]          req;
    logic [1:0]          we_in;
    logic [ADDR_W-1:0]   addr_in  [2];
    logic [DATA_W-1:0]   wdata_in [2];
    logic [1:0]          gnt;
    logic [1:0]          done;

    assign req         = {req1, req0};
    assign we_in       = {we1, we0};
    assign addr_in[0]  = addr0;
    assign addr_in[1]  = addr1;
    assign wdata_in[0] = wdata0;
    assign wdata_in[1] = wdata1;

    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        win_next   = win_reg;
        we_next    = we_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        pick       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    // On a tie the port not granted most recently wins.
                    pick       = (req == 2'b11) ? ~last_reg : req[1];
                    win_next   = pick;
                    last_next  = pick;
                    we_next    = we_in[pick];
                    addr_next  = addr_in[pick];
                    wdata_next = wdata_in[pick];
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (!we_reg) begin
                    rdata_next = mem_data;
                end
                state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_L) begin
        if (!reset_L) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
            win_reg   <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            win_reg   <= win_next;
            we_reg    <= we_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign gnt[gi]  = (state_reg == ACCESS) && (win_reg == 1'(gi));
            assign done[gi] = (state_reg == RESP)   && (win_reg == 1'(gi));
        end
    endgenerate

    assign gnt0  = gnt[0];
    assign gnt1  = gnt[1];
    assign done0 = done[0];
    assign done1 = done[1];

    assign rdata       = rdata_reg;
    assign mem_address = addr_reg;
    assign mem_active  = (state_reg == ACCESS);
    assign mem_we_L    = (mem_active && we_reg)  ? MEM_WR : MEM_WR_OFF;
    assign mem_re_L    = (mem_active && !we_reg) ? MEM_RD : MEM_RD_OFF;
    // Only a write ACCESS owns the bus; RESP/IDLE give the turnaround gap.
    assign mem_data    = (mem_active && we_reg) ? wdata_reg : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a 256-word memory model on the bus.
// Undriven bus floats to all-ones, so a released bus reads 16'hFFFF.

module tb_mem_bus_arbiter;
    import mem_bus_pkg::*;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    logic              clock = 1'b0;
    logic              reset_L = 1'b0;
    logic              req0 = 1'b0, req1 = 1'b0;
    logic              we0 = 1'b0, we1 = 1'b0;
    logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
    logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
    logic              gnt0, gnt1, done0, done1, mem_active;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_address;
    wr_cond_code_t     mem_we_L;
    rd_cond_code_t     mem_re_L;
    tri1 [DATA_W-1:0]  mem_data;

    logic [DATA_W-1:0] mem [256];
    int vectors = 0;
    int miscompares = 0;

    // {gnt0, gnt1, done0, done1} per cycle with both ports requesting
    logic [3:0] rr_exp [11] = '{4'b1000, 4'b0010, 4'b0000, 4'b0100, 4'b0001, 4'b0000,
                                4'b1000, 4'b0010, 4'b0000, 4'b0100, 4'b0001};

    always #5 clock = ~clock;

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock(clock), .reset_L(reset_L),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .mem_address(mem_address), .mem_data(mem_data),
        .mem_we_L(mem_we_L), .mem_re_L(mem_re_L), .mem_active(mem_active)
    );

    assign mem_data = (mem_active && mem_re_L == MEM_RD) ? mem[mem_address[7:0]] : 'z;
    always @(posedge clock) begin
        if (mem_active && mem_we_L == MEM_WR) mem[mem_address[7:0]] <= mem_data;
    end

    task automatic check_value(input string tag, input logic [31:0] seen, input logic [31:0] want);
        vectors++;
        if (seen !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, want %h", tag, seen, want);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check_hs(input string tag, input logic [3:0] want);
        check_value(tag, {gnt0, gnt1, done0, done1}, want);
    endtask

    // Protocol invariants sampled mid-cycle throughout the run.
    always @(negedge clock) begin
        check_value("strobe_excl", (mem_we_L == MEM_WR && mem_re_L == MEM_RD), 0);
        check_value("onehot", {gnt0 & gnt1, done0 & done1, (gnt0 | gnt1) & (done0 | done1)}, 0);
        check_value("active_vs_gnt", mem_active, gnt0 | gnt1);
        if (!mem_active) check_value("bus_released", mem_data, 16'hFFFF);
        else if (mem_re_L == MEM_RD) check_value("rd_bus_known", $isunknown(mem_data), 0);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h12] = 16'hBEEF;

        repeat (2) tick;
        check_value("rst_ctrl", {gnt0, gnt1, done0, done1, mem_active}, 0);
        check_value("rst_rdata", rdata, 0);
        check_value("rst_addr", mem_address, 0);
        check_value("rst_strobes", {mem_we_L, mem_re_L}, {MEM_WR_OFF, MEM_RD_OFF});
        check_value("rst_bus", mem_data, 16'hFFFF);
        #2 reset_L = 1'b1;
        tick;

        // single read by port 0
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0012;
        tick;
        check_hs("rd_gnt", 4'b1000);
        check_value("rd_strobes", {mem_we_L, mem_re_L}, {MEM_WR_OFF, MEM_RD});
        check_value("rd_addr", mem_address, 16'h0012);
        tick;
        check_hs("rd_done", 4'b0010);
        check_value("rd_data", rdata, 16'hBEEF);
        req0 = 1'b0;
        tick;
        check_hs("rd_idle", 4'b0000);

        // port 1 write then read back
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0040; wdata1 = 16'h1234;
        tick;
        check_hs("wr_gnt", 4'b0100);
        check_value("wr_strobes", {mem_we_L, mem_re_L}, {MEM_WR, MEM_RD_OFF});
        check_value("wr_bus", mem_data, 16'h1234);
        check_value("wr_addr", mem_address, 16'h0040);
        tick;
        check_hs("wr_done", 4'b0001);
        check_value("wr_bus_off", mem_data, 16'hFFFF);
        check_value("wr_rdata_kept", rdata, 16'hBEEF);
        check_value("wr_mem", mem[8'h40], 16'h1234);
        req1 = 1'b0;
        tick;
        req1 = 1'b1; we1 = 1'b0;
        tick;
        check_hs("rb_gnt", 4'b0100);
        tick;
        check_hs("rb_done", 4'b0001);
        check_value("rb_data", rdata, 16'h1234);
        req1 = 1'b0;
        tick;

        // simultaneous requests right after reset, then continuous alternation
        reset_L = 1'b0;
        #2 reset_L = 1'b1;
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0012;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0040;
        for (int i = 0; i < 11; i++) begin
            tick;
            check_hs($sformatf("rr_%0d", i), rr_exp[i]);
            if (rr_exp[i][1]) check_value($sformatf("rr_rd0_%0d", i), rdata, 16'hBEEF);
            if (rr_exp[i][0]) check_value($sformatf("rr_rd1_%0d", i), rdata, 16'h1234);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick;
        check_hs("rr_idle", 4'b0000);
        tick;
        check_hs("rr_quiet", 4'b0000);

        // mixed write/read contention; port 1 was granted last so port 0 wins
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0010; wdata0 = 16'h55AA;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0012;
        tick;
        check_hs("mx_gnt0", 4'b1000);
        check_value("mx_bus", mem_data, 16'h55AA);
        tick;
        check_hs("mx_done0", 4'b0010);
        req0 = 1'b0;
        tick;
        check_hs("mx_idle", 4'b0000);
        tick;
        check_hs("mx_gnt1", 4'b0100);
        check_value("mx_rd_addr", mem_address, 16'h0012);
        tick;
        check_hs("mx_done1", 4'b0001);
        check_value("mx_rdata", rdata, 16'hBEEF);
        req1 = 1'b0;
        tick;

        // reset in the middle of a write ACCESS
        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0020; wdata1 = 16'h0BAD;
        tick;
        check_hs("ra_gnt", 4'b0100);
        #2 reset_L = 1'b0;
        #1;
        check_value("ra_ctrl", {gnt0, gnt1, done0, done1, mem_active}, 0);
        check_value("ra_addr", mem_address, 0);
        check_value("ra_rdata", rdata, 0);
        check_value("ra_strobes", {mem_we_L, mem_re_L}, {MEM_WR_OFF, MEM_RD_OFF});
        check_value("ra_bus", mem_data, 16'hFFFF);
        req1 = 1'b0; we1 = 1'b0;
        tick;
        check_hs("ra_nodone", 4'b0000);
        check_value("ra_mem", mem[8'h20], 16'h0000);
        tick;
        check_hs("ra_hold", 4'b0000);
        #2 reset_L = 1'b1;

        // first tie after reset goes to port 0; held port 0 yields to port 1
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0040;
        tick;
        check_hs("hd_gnt0", 4'b1000);
        tick;
        check_hs("hd_done0", 4'b0010);
        check_value("hd_rd0", rdata, 16'h55AA);
        tick;
        check_hs("hd_idle0", 4'b0000);
        tick;
        check_hs("hd_gnt1", 4'b0100);
        tick;
        check_hs("hd_done1", 4'b0001);
        check_value("hd_rd1", rdata, 16'h1234);
        req1 = 1'b0;
        tick;
        check_hs("hd_idle1", 4'b0000);
        tick;
        check_hs("hd_regnt0", 4'b1000);
        tick;
        check_hs("hd_redone0", 4'b0010);
        check_value("hd_rd0b", rdata, 16'h55AA);
        req0 = 1'b0;
        tick;
        check_hs("hd_end", 4'b0000);
        tick;
        check_hs("hd_quiet", 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
